siren_detector: RTL and testbench

//  Listen side of the buzzer/siren tone path. Samples an asynchronous square-wave input
//  (mic comparator or looped-back speaker line) and measures its period in clk cycles.

---
 rtl/siren_detector.sv | 85 ++++++++
 tb/tb_siren_detector.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/siren_detector.sv
// siren_detector: measures sig_in period, classifies tone A/B, locks after MATCH_N matches, flags A<->B siren
module siren_detector #(
  parameter int PER_A   = 27780,
  parameter int PER_B   = 14206,
  parameter int TOL     = 256,
  parameter int MATCH_N = 4,
  parameter int MAX_PER = 65535,
  parameter int SW_MAX  = 75000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sig_in,
  output logic [15:0] period,
  output logic        period_stb,
  output logic [1:0]  tone,
  output logic        tone_valid,
  output logic        siren
);
  localparam int MW = $clog2(MATCH_N + 1);
  localparam logic [16:0] PA = 17'(PER_A);
  localparam logic [16:0] PB = 17'(PER_B);
  localparam logic [16:0] TL = 17'(TOL);
  localparam logic [15:0] MP = 16'(MAX_PER);
  localparam logic [26:0] SM = 27'(SW_MAX);
  localparam logic [MW-1:0] MN = MW'(MATCH_N);
  typedef enum logic [1:0] {IDLE, MEAS, LOCK} state_t;
  state_t state, state_n;
  logic s1, s2, s_d, rise, tout, meas, match, lock, chg, ab, stb_n, siren_n;
  logic [16:0] pc, da, db;
  logic [15:0] per_cnt, per_cnt_n, period_n;
  logic [MW-1:0] mcnt, mcnt_n;
  logic [1:0] cls, cand, cand_n, tone_n, alt, alt_n;
  logic [26:0] sw_cnt, sw_n;
  always_comb begin
    rise = s2 & ~s_d;
    tout = per_cnt == MP && !rise;
    meas = rise && state != IDLE;
    pc = {1'b0, per_cnt};
    da = pc > PA ? pc - PA : PA - pc;
    db = pc > PB ? pc - PB : PB - pc;
    cls = da <= TL ? 2'd1 : db <= TL ? 2'd2 : 2'd0;
    match = cls == cand && cls != 2'd0;
    per_cnt_n = rise ? 16'd1 : per_cnt == MP ? per_cnt : per_cnt + 16'd1;
    mcnt_n = tout ? '0 : !meas ? mcnt : match ? (mcnt == MN ? mcnt : mcnt + 1'b1) : (cls == 2'd0 ? '0 : MW'(1));
    cand_n = tout ? 2'd0 : meas ? cls : cand;
    lock = meas && cls != 2'd0 && mcnt_n == MN;
    state_n = tout ? IDLE : (state == IDLE && rise) ? MEAS : lock ? LOCK : state;
    tone_n = tout ? 2'd0 : lock ? cls : tone;
    chg = tone_n != tone && tone_n != 2'd0;
    ab = chg && tone != 2'd0;
    sw_n = (tout || chg) ? '0 : sw_cnt == SM ? sw_cnt : sw_cnt + 27'd1;
    alt_n = (tout || (chg && tone == 2'd0)) ? 2'd0 : ab ? (sw_cnt < SM ? (alt == 2'd2 ? 2'd2 : alt + 2'd1) : 2'd1) : alt;
    siren_n = alt_n == 2'd2 && sw_n != SM;
    stb_n = meas;
    period_n = meas ? per_cnt : period;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {s1, s2, s_d} <= '0;
      state <= IDLE;
      per_cnt <= '0;
      mcnt <= '0;
      cand <= '0;
      sw_cnt <= '0;
      alt <= '0;
      period <= '0;
      period_stb <= 1'b0;
      tone <= '0;
      tone_valid <= 1'b0;
      siren <= 1'b0;
    end else begin
      {s1, s2, s_d} <= {sig_in, s1, s2};
      state <= state_n;
      per_cnt <= per_cnt_n;
      mcnt <= mcnt_n;
      cand <= cand_n;
      sw_cnt <= sw_n;
      alt <= alt_n;
      period <= period_n;
      period_stb <= stb_n;
      tone <= tone_n;
      tone_valid <= state_n == LOCK;
      siren <= siren_n;
    end
endmodule

// File: tb/tb_siren_detector.sv
// tb_siren_detector: directed table-driven check of siren_detector with scaled-down timing
module tb_siren_detector;
  localparam int PA = 278;
  localparam int PB = 142;
  localparam int TL = 8;
  localparam int MP = 1000;
  localparam int SM = 2000;
  typedef struct {int len; logic [1:0] tone; logic valid; logic siren;} vec_t;
  typedef struct {logic [15:0] period; logic [1:0] tone; logic valid; logic siren; int cyc;} cap_t;
  logic clk = 0, rst = 1, sig_in = 0;
  logic [15:0] period;
  logic period_stb, tone_valid, siren;
  logic [1:0] tone;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  vec_t tbl[$];
  cap_t cap[$];
  siren_detector #(.PER_A(PA), .PER_B(PB), .TOL(TL), .MATCH_N(4), .MAX_PER(MP), .SW_MAX(SM)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .period(period), .period_stb(period_stb),
    .tone(tone), .tone_valid(tone_valid), .siren(siren)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc++;
    #1;
    if (period_stb) cap.push_back('{period, tone, tone_valid, siren, cyc});
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic add(input int len, input logic [1:0] t, input logic v, input logic s);
    tbl.push_back('{len, t, v, s});
  endtask
  task automatic wave(input int len);
    sig_in = 1;
    repeat (len / 2) @(negedge clk);
    sig_in = 0;
    repeat (len - len / 2) @(negedge clk);
  endtask
  task automatic do_reset();
    sig_in = 0;
    @(negedge clk);
    rst = 1;
    repeat (4) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
  endtask
  task automatic run_table(input string tag, input int lo, input int hi);
    cap.delete();
    for (int i = lo; i <= hi; i++) wave(tbl[i].len);
    sig_in = 1;
    repeat (8) @(negedge clk);
    chk({tag, " stb count"}, cap.size(), hi - lo + 1);
    for (int i = lo; i <= hi; i++)
      if (i - lo < cap.size())
        chk($sformatf("%s vec%0d {period,tone,valid,siren}", tag, i - lo),
            32'({cap[i-lo].period, cap[i-lo].tone, cap[i-lo].valid, cap[i-lo].siren}),
            32'({16'(tbl[i].len), tbl[i].tone, tbl[i].valid, tbl[i].siren}));
  endtask
  initial begin
    int g2, g3, gl, g6, g5, ge, k, t0;
    g2 = tbl.size();
    for (int i = 0; i < 5; i++) add(PA, i >= 3 ? 2'd1 : 2'd0, i >= 3, 0);
    g3 = tbl.size();
    for (int i = 0; i < 4; i++) add(PB + TL, i >= 3 ? 2'd2 : 2'd0, i >= 3, 0);
    add(PB + TL + 1, 2, 1, 0);
    for (int i = 0; i < 4; i++) add(PA, i >= 3 ? 2'd1 : 2'd2, 1, 0);
    gl = tbl.size();
    for (int i = 0; i < 4; i++) add(PB - TL, i >= 3 ? 2'd2 : 2'd0, i >= 3, 0);
    add(PB - TL - 1, 2, 1, 0);
    g6 = tbl.size();
    add(PA, 0, 0, 0); add(PA, 0, 0, 0); add(200, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(PA, i >= 3 ? 2'd1 : 2'd0, i >= 3, 0);
    g5 = tbl.size();
    for (int i = 0; i < 24; i++)
      add(i / 8 == 1 ? PB : PA, i < 3 ? 2'd0 : i < 11 ? 2'd1 : i < 19 ? 2'd2 : 2'd1, i >= 3, i >= 19);
    ge = tbl.size();
    sig_in = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    chk("reset outputs", 32'({period, period_stb, tone, tone_valid, siren}), 0);
    rst = 0;
    repeat (2) @(negedge clk);
    run_table("T2", g2, g3 - 1);
    chk("T1 locked before reset", tone_valid, 1);
    @(negedge clk);
    #3 rst = 1;
    #1 chk("T1 async clear", 32'({period, period_stb, tone, tone_valid, siren}), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sig_in = ~sig_in;
      chk("T1 held in reset", 32'({period, period_stb, tone, tone_valid, siren}), 0);
    end
    sig_in = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    run_table("T3", g3, gl - 1);
    do_reset();
    run_table("T3lo", gl, g6 - 1);
    do_reset();
    run_table("T6", g6, g5 - 1);
    do_reset();
    cap.delete();
    for (int i = 0; i < 4; i++) wave(PA);
    sig_in = 1;
    k = 0;
    while (cap.size() < 4 && k < 50) begin @(posedge clk); #1; k++; end
    chk("T4 lock stb count", cap.size(), 4);
    t0 = cap.size() >= 4 ? cap[3].cyc : cyc;
    if (cap.size() >= 4) chk("T4 locked tone", 32'({cap[3].tone, cap[3].valid}), 32'({2'd1, 1'b1}));
    k = 0;
    while (tone_valid !== 1'b0 && k < 2 * MP) begin @(posedge clk); #1; k++; end
    chk("T4 timeout cycles", cyc - t0, MP);
    chk("T4 cleared tone", 32'({tone, tone_valid, siren}), 0);
    @(negedge clk);
    sig_in = 0;
    repeat (5) @(negedge clk);
    sig_in = 1;
    repeat (20) @(negedge clk);
    chk("T4 arm rise gives no stb", cap.size(), 4);
    do_reset();
    run_table("T5", g5, ge - 1);
    t0 = cap.size() > 19 ? cap[19].cyc : 0;
    chk("T5 siren before hold", siren, 1);
    fork
      repeat (10) wave(PA);
      begin
        k = 0;
        while (siren !== 1'b0 && k < 3 * SM) begin @(posedge clk); #1; k++; end
        chk("T5 siren drop cycles", cyc - t0, SM);
        chk("T5 tone held A", 32'({tone, tone_valid}), 32'({2'd1, 1'b1}));
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
